// File: rtl/button_event_queue.sv
// Debounced controller buttons turned into press events held in a show-ahead FIFO.
// Define BUTTON_AUTO_REPEAT_EN to auto-repeat left, right and down while held.
module button_event_queue #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [6:0]                    btn_raw,
    input  logic                          rd_en,
    output logic [31:0]                   event_code,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    function automatic logic [3:0] code_of(input int i);
        case (i)
            0:       code_of = 4'd1;
            1:       code_of = 4'd2;
            2:       code_of = 4'd3;
            3:       code_of = 4'd4;
            4:       code_of = 4'd7;
            5:       code_of = 4'd8;
            default: code_of = 4'd9;
        endcase
    endfunction

    logic [6:0]    sync1, sync2;
    logic [6:0]    stable, stable_d;
    logic [CW-1:0] db_cnt [7];
    logic [6:0]    press, pending, grant;
    logic [3:0]    push_code;
    logic          push, pop, full;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [3:0]    mem [FIFO_DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 7; i++) db_cnt[i] <= '0;
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 7; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int RW = $clog2(4 * DEBOUNCE_CYCLES + 1);
    localparam logic [RW-1:0] FIRST_LAST = RW'(4 * DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] NEXT_LAST  = RW'(DEBOUNCE_CYCLES - 1);

    logic [RW-1:0] rep_cnt [1:3];
    logic [3:1]    rep_first;
    logic [6:0]    rep;

    // Counting starts the cycle after the press pulse, so the first
    // repeat lands exactly 4*DEBOUNCE_CYCLES after the press event.
    always_comb begin
        rep = '0;
        for (int i = 1; i <= 3; i++) begin
            rep[i] = stable[i] & stable_d[i] &
                     (rep_cnt[i] == (rep_first[i] ? FIRST_LAST : NEXT_LAST));
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 1; i <= 3; i++) begin
            if (reset || !stable[i]) begin
                rep_cnt[i]   <= '0;
                rep_first[i] <= 1'b1;
            end else if (stable_d[i]) begin
                if (rep[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_first[i] <= 1'b0;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = (stable & ~stable_d) | rep;
`else
    assign press = stable & ~stable_d;
`endif

    // Highest bit wins, which is also the highest code.
    always_comb begin
        grant     = '0;
        push_code = '0;
        for (int i = 0; i < 7; i++) begin
            if (pending[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                push_code = code_of(i);
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign pop   = rd_en & ~empty;
    assign push  = (|pending) & (~full | (rd_en & ~empty));

    always_ff @(posedge clock) begin
        if (reset) begin
            pending  <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            pending  <= (pending & ~(push ? grant : 7'b0)) | press;
            overflow <= overflow | (|(press & pending));
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_code;
    end

    assign event_code = empty ? 32'd0 : {28'd0, mem[rd_ptr[AW-1:0]]};

endmodule
